// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC feeder: FSM encoding, result flag bit
// positions and the quiet-NaN returned when a request times out.
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_TMO  = 3;

  localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; DEPTH must be a power
// of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cordic_feeder.sv
// Queues angle requests and runs them one at a time through the CORDIC
// beg/ready/ack handshake. Define CORDIC_FEEDER_TIMEOUT_EN to bound WAIT.
module cordic_feeder
  import cordic_pkg::*;
#(
  parameter int W              = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_angle,
  input  logic         in_op,
  input  logic [1:0]   in_region,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_flags,
  output logic         cordic_beg,
  output logic         cordic_ack,
  output logic         cordic_op,
  output logic [W-1:0] cordic_data_in,
  output logic [1:0]   cordic_region,
  input  logic         cordic_ready,
  input  logic         cordic_busy,
  input  logic [W-1:0] cordic_data_out,
  input  logic         cordic_ovf,
  input  logic         cordic_unf,
  input  logic         cordic_zero
);
  localparam int FW = W + 3;

  state_e        state_q, state_d;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_rdata;
  logic          op_q;
  logic [W-1:0]  angle_q;
  logic [1:0]    region_q;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [3:0]    out_flags_q, out_flags_d;
  logic          tmo_hit;

  sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({in_angle, in_op, in_region}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef CORDIC_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) wait_cnt_q <= '0;
    else                           wait_cnt_q <= wait_cnt_q + CW'(1);
  end

  // Fires on the last allowed WAIT cycle if ready still has not arrived.
  assign tmo_hit = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;

  // TIMEOUT_CYCLES only matters when the timeout is compiled in.
  if (TIMEOUT_CYCLES < 0) begin : g_tmo_unused
  end
`endif

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !out_valid_q && !cordic_busy) begin
          fifo_pop = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cordic_ready) begin
          out_data_d             = cordic_data_out;
          out_flags_d            = 4'b0000;
          out_flags_d[FLAG_ZERO] = cordic_zero;
          out_flags_d[FLAG_UNF]  = cordic_unf;
          out_flags_d[FLAG_OVF]  = cordic_ovf;
          out_valid_d            = 1'b1;
          state_d                = ST_ACK;
        end else if (tmo_hit) begin
          out_data_d            = W'(TIMEOUT_NAN);
          out_flags_d           = 4'b0000;
          out_flags_d[FLAG_TMO] = 1'b1;
          out_valid_d           = 1'b1;
          state_d               = ST_HOLD;
        end
      end
      ST_ACK: begin
        if (!cordic_ready) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      op_q        <= 1'b0;
      angle_q     <= '0;
      region_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      if (fifo_pop) {angle_q, op_q, region_q} <= fifo_rdata;
    end
  end

  assign in_ready       = !fifo_full;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_flags      = out_flags_q;
  assign cordic_beg     = (state_q == ST_LAUNCH);
  assign cordic_ack     = (state_q == ST_ACK);
  assign cordic_op      = op_q;
  assign cordic_data_in = angle_q;
  assign cordic_region  = region_q;

endmodule
